pixelate: RTL and testbench
===========================

// Module: pixelate
// PURPOSE
//  Downsamples a full-res RGB565 raster stream into a coarse BLOCKxBLOCK grid.
//  Each output pixel is the mean colour of one BLOCKxBLOCK tile.
//  Sits upstream of grid-domain processing, which unpixelate later maps back to
//  full-res tile centres. Default 320x240 -> 32x24 tiles of 10x10.
// PARAMETERS
//  H_ACTIVE  320  active pixels per line; hcount_in >= H_ACTIVE ignored
//  V_ACTIVE  240  active lines per frame; vcount_in >= V_ACTIVE ignored
//  BLOCK     10   tile edge in pixels; H_ACTIVE/BLOCK <= 32, V_ACTIVE/BLOCK <= 32
// PORTS
//  clk_in          in   1   single system clock, all logic on posedge
//  rst_n_in        in   1   reset, asynchronous assert, active-low
//  data_valid_in   in   1   pixel_in/hcount_in/vcount_in valid this cycle
//  hcount_in       in   10  full-res column
//  vcount_in       in   11  full-res row
//  pixel_in        in   16  RGB565 {R[4:0],G[5:0],B[4:0]}
//  data_valid_out  out  1   one-cycle pulse: tile average valid
//  hcount_out      out  5   tile column index
//  vcount_out      out  5   tile row index
//  pixel_out       out  16  RGB565 tile average
// BEHAVIOUR
//  - Reset (rst_n_in=0): all outputs 0, counters 0, accumulators 0; async assert, sync release.
//  - Input order: raster, each line starts at hcount_in=0, hcount_in +1 per valid beat; valid gaps allowed.
//  - Counters advance only on accepted beats (valid, in range):
//    . hcount_in==0: sub_h=0, col=0; vcount_in==0 -> sub_v=0,row=0, else sub_v+1 (wrap at BLOCK -> row+1).
//    . otherwise sub_h+1; at sub_h==BLOCK-1 wrap to 0, col+1.
//  - Row accumulator: array[32] of {sumR 12b, sumG 13b, sumB 12b}, flops.
//    Per accepted beat, entry[col] <= (sub_h==0 && sub_v==0) ? pixel : entry[col]+pixel.
//    The first pixel of a tile overwrites, so no explicit clear. Unused entries hold their value.
//  - Tile completion: accepted beat with sub_h==BLOCK-1 && sub_v==BLOCK-1.
//    . Stage 1 latches final sums (including that beat), col, and row.
//    . Stage 2 computes each channel as (sum*RECIP)>>16, RECIP=656 for BLOCK=10, saturated to field max.
//    . data_valid_out=1 exactly 2 cycles after the completing beat, held for 1 cycle.
//  - Outputs hold their last value while data_valid_out=0.
//  - Partial tiles at the right/bottom edge (H_ACTIVE or V_ACTIVE not a multiple of BLOCK) never emit.
//  - Out-of-range beats: no counter or accumulator update, no output.
//  - Back-to-back completions (one per BLOCK beats minimum) are fully pipelined; no stall, no ready.
//  - Reset mid-frame: pipeline flushed, no data_valid_out until a full tile is seen after (0,0).
//  - Mid-frame restart (valid beat at hcount_in=0, vcount_in=0): counters resync.
//    Tiles in progress are discarded via the overwrite rule.
// STRUCTURE
//  - pixelate_pkg: BLOCK default, RECIP, RGB565 field widths/slices, sum widths,
//    typedef rgb_sum_t {sumR,sumG,sumB}.
//  - Sub-module rgb565_block_avg: stage-2 reciprocal multiply + saturate
//    (rgb_sum_t in, 16b RGB565 out, 1 cycle registered).
//  - Counters, accumulator array and stage 1 stay in pixelate.
// TESTING
//  1. Full 320x240 frame, all pixels 16'hF800
//     -> 768 pulses, hcount_out 0..31 per row, vcount_out 0..23, pixel_out=16'hF800 each.
//  2. Tile (0,0) pixels = 16'h0841 (R1,G2,B1), rest 0 -> tile(0,0) pixel_out=16'h0841, all others 0.
//  3. Single completing beat at (9,9) -> data_valid_out at exactly cycle+2.
//     Insert random valid gaps -> same averages and order as gap-free.
//  4. Drive beats with hcount_in=320..329 and vcount_in=240 mixed in
//     -> no accumulator change, outputs identical to test 1.
//  5. Assert rst_n_in asynchronously at line 55
//     -> outputs 0 immediately; after release + new frame from (0,0), first pulse is tile (0,0) with correct average.
//  6. Frame 2 colour 16'h001F after frame 1 16'hF800 -> every frame-2 tile = 16'h001F (no carry-over).

Source files
------------

// File: rtl/pixelate_pkg.sv
// Shared definitions for the pixelate tile-averaging path.
// Holds RGB565 field layout, accumulator sum widths, the per-tile
// reciprocal used to turn a tile sum into a mean, and the accumulator
// payload struct with its init/add helpers.
package pixelate_pkg;

    localparam int unsigned BLOCK_DEF  = 10;
    localparam int unsigned PIX_W      = 16;
    localparam int unsigned R_W        = 5;
    localparam int unsigned G_W        = 6;
    localparam int unsigned B_W        = 5;
    localparam int unsigned R_LSB      = 11;
    localparam int unsigned G_LSB      = 5;
    localparam int unsigned B_LSB      = 0;
    localparam int unsigned SUM_R_W    = 12;
    localparam int unsigned SUM_G_W    = 13;
    localparam int unsigned SUM_B_W    = 12;
    localparam int unsigned MAX_TILES  = 32;
    localparam int unsigned TILE_IDX_W = 5;
    localparam int unsigned RECIP_SHIFT = 16;

    // ceil(2^16 / (block*block)); rounding up keeps full-scale tiles at full scale
    function automatic int unsigned block_recip(input int unsigned block);
        return ((32'd1 << RECIP_SHIFT) + block * block - 32'd1) / (block * block);
    endfunction

    localparam int unsigned RECIP = block_recip(BLOCK_DEF);

    typedef struct packed {
        logic [SUM_R_W-1:0] sum_r;
        logic [SUM_G_W-1:0] sum_g;
        logic [SUM_B_W-1:0] sum_b;
    } rgb_sum_t;

    // First pixel of a tile: sums start from this pixel alone
    function automatic rgb_sum_t rgb_sum_init(input logic [PIX_W-1:0] pix);
        rgb_sum_t s;
        s.sum_r = SUM_R_W'(pix[R_LSB +: R_W]);
        s.sum_g = SUM_G_W'(pix[G_LSB +: G_W]);
        s.sum_b = SUM_B_W'(pix[B_LSB +: B_W]);
        return s;
    endfunction

    function automatic rgb_sum_t rgb_sum_add(input rgb_sum_t acc, input logic [PIX_W-1:0] pix);
        rgb_sum_t s;
        s.sum_r = acc.sum_r + SUM_R_W'(pix[R_LSB +: R_W]);
        s.sum_g = acc.sum_g + SUM_G_W'(pix[G_LSB +: G_W]);
        s.sum_b = acc.sum_b + SUM_B_W'(pix[B_LSB +: B_W]);
        return s;
    endfunction

endpackage

// File: rtl/rgb565_block_avg.sv
// Converts a finished tile sum into its mean RGB565 colour.
// Each channel is (sum * RECIP_P) >> 16, clamped to the channel maximum.
// Ports: clk_in/rst_n_in clock and async active-low reset; valid_in/sum_in
// tile sum strobe and payload; valid_out one-cycle strobe, pixel_out mean
// colour (holds between strobes). One cycle registered latency.
module rgb565_block_avg
    import pixelate_pkg::*;
#(
    parameter int unsigned RECIP_P = RECIP
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             valid_in,
    input  rgb_sum_t         sum_in,
    output logic             valid_out,
    output logic [PIX_W-1:0] pixel_out
);

    localparam int unsigned R_MAX = (1 << R_W) - 1;
    localparam int unsigned G_MAX = (1 << G_W) - 1;
    localparam int unsigned B_MAX = (1 << B_W) - 1;

    logic             valid_q, valid_d;
    logic [PIX_W-1:0] pixel_q, pixel_d;

    function automatic logic [PIX_W-1:0] avg_pixel(input rgb_sum_t s);
        logic [31:0] r, g, b;
        r = (32'(s.sum_r) * 32'(RECIP_P)) >> RECIP_SHIFT;
        g = (32'(s.sum_g) * 32'(RECIP_P)) >> RECIP_SHIFT;
        b = (32'(s.sum_b) * 32'(RECIP_P)) >> RECIP_SHIFT;
        if (r > R_MAX) r = R_MAX;
        if (g > G_MAX) g = G_MAX;
        if (b > B_MAX) b = B_MAX;
        return {R_W'(r), G_W'(g), B_W'(b)};
    endfunction

    // Next-state: capture a new mean only on a strobe, otherwise hold
    always_comb begin
        valid_d = valid_in;
        pixel_d = pixel_q;
        if (valid_in) begin
            pixel_d = avg_pixel(sum_in);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            valid_q <= 1'b0;
            pixel_q <= '0;
        end else begin
            valid_q <= valid_d;
            pixel_q <= pixel_d;
        end
    end

    assign valid_out = valid_q;
    assign pixel_out = pixel_q;

endmodule

// File: rtl/pixelate.sv
// Downsamples a raster RGB565 stream into BLOCKxBLOCK tile means.
// Ports: clk_in, rst_n_in (async active-low); data_valid_in, hcount_in,
// vcount_in, pixel_in: raster beat; data_valid_out: one-cycle pulse two
// cycles after a tile's last beat; hcount_out/vcount_out: tile column/row;
// pixel_out: tile mean colour. Outputs hold between pulses.
module pixelate
    import pixelate_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 320,
    parameter int unsigned V_ACTIVE = 240,
    parameter int unsigned BLOCK    = BLOCK_DEF
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        data_valid_in,
    input  logic [9:0]  hcount_in,
    input  logic [10:0] vcount_in,
    input  logic [15:0] pixel_in,
    output logic        data_valid_out,
    output logic [4:0]  hcount_out,
    output logic [4:0]  vcount_out,
    output logic [15:0] pixel_out
);

    localparam int unsigned NUM_COLS = H_ACTIVE / BLOCK;
    localparam int unsigned NUM_ROWS = V_ACTIVE / BLOCK;
    localparam int unsigned SUB_W    = (BLOCK > 1) ? $clog2(BLOCK) : 1;
    localparam int unsigned CNT_W    = TILE_IDX_W + 1;
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(BLOCK - 1);

    logic [SUB_W-1:0]      sub_h_q, sub_h_d;
    logic [SUB_W-1:0]      sub_v_q, sub_v_d;
    logic [CNT_W-1:0]      col_q, col_d;
    logic [CNT_W-1:0]      row_q, row_d;
    logic                  synced_q, synced_d;
    rgb_sum_t              acc_q [MAX_TILES];
    rgb_sum_t              acc_d [MAX_TILES];
    logic                  s1_valid_q, s1_valid_d;
    rgb_sum_t              s1_sum_q, s1_sum_d;
    logic [TILE_IDX_W-1:0] s1_col_q, s1_col_d;
    logic [TILE_IDX_W-1:0] s1_row_q, s1_row_d;
    logic [TILE_IDX_W-1:0] hcount_out_q, hcount_out_d;
    logic [TILE_IDX_W-1:0] vcount_out_q, vcount_out_d;

    logic                  accept;
    logic [TILE_IDX_W-1:0] idx;
    rgb_sum_t              sum_new;

    assign accept = data_valid_in && (32'(hcount_in) < H_ACTIVE) && (32'(vcount_in) < V_ACTIVE);

    // Raster counters, row accumulator update and stage-1 capture
    always_comb begin
        sub_h_d    = sub_h_q;
        sub_v_d    = sub_v_q;
        col_d      = col_q;
        row_d      = row_q;
        synced_d   = synced_q;
        acc_d      = acc_q;
        s1_valid_d = 1'b0;
        s1_sum_d   = s1_sum_q;
        s1_col_d   = s1_col_q;
        s1_row_d   = s1_row_q;
        idx        = '0;
        sum_new    = '0;

        if (accept) begin
            if (hcount_in == '0) begin
                sub_h_d = '0;
                col_d   = '0;
                if (vcount_in == '0) begin
                    sub_v_d  = '0;
                    row_d    = '0;
                    synced_d = 1'b1;
                end else if (sub_v_q == SUB_LAST) begin
                    sub_v_d = '0;
                    row_d   = row_q + CNT_W'(1);
                end else begin
                    sub_v_d = sub_v_q + SUB_W'(1);
                end
            end else if (sub_h_q == SUB_LAST) begin
                sub_h_d = '0;
                col_d   = col_q + CNT_W'(1);
            end else begin
                sub_h_d = sub_h_q + SUB_W'(1);
            end

            // Columns of a partial right-edge tile have no accumulator slot
            if (32'(col_d) < NUM_COLS) begin
                idx = TILE_IDX_W'(col_d);
                // Tile's first pixel overwrites, so stale sums never need clearing
                if (sub_h_d == '0 && sub_v_d == '0) begin
                    sum_new = rgb_sum_init(pixel_in);
                end else begin
                    sum_new = rgb_sum_add(acc_q[idx], pixel_in);
                end
                acc_d[idx] = sum_new;

                // Only emit tiles whose rows were all seen since a frame start
                if (sub_h_d == SUB_LAST && sub_v_d == SUB_LAST &&
                    (32'(row_d) < NUM_ROWS) && synced_d) begin
                    s1_valid_d = 1'b1;
                    s1_sum_d   = sum_new;
                    s1_col_d   = idx;
                    s1_row_d   = TILE_IDX_W'(row_d);
                end
            end
        end
    end

    // Tile coordinates follow stage 1 into the output register
    always_comb begin
        hcount_out_d = hcount_out_q;
        vcount_out_d = vcount_out_q;
        if (s1_valid_q) begin
            hcount_out_d = s1_col_q;
            vcount_out_d = s1_row_q;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sub_h_q      <= '0;
            sub_v_q      <= '0;
            col_q        <= '0;
            row_q        <= '0;
            synced_q     <= 1'b0;
            for (int i = 0; i < int'(MAX_TILES); i++) begin
                acc_q[i] <= '0;
            end
            s1_valid_q   <= 1'b0;
            s1_sum_q     <= '0;
            s1_col_q     <= '0;
            s1_row_q     <= '0;
            hcount_out_q <= '0;
            vcount_out_q <= '0;
        end else begin
            sub_h_q      <= sub_h_d;
            sub_v_q      <= sub_v_d;
            col_q        <= col_d;
            row_q        <= row_d;
            synced_q     <= synced_d;
            acc_q        <= acc_d;
            s1_valid_q   <= s1_valid_d;
            s1_sum_q     <= s1_sum_d;
            s1_col_q     <= s1_col_d;
            s1_row_q     <= s1_row_d;
            hcount_out_q <= hcount_out_d;
            vcount_out_q <= vcount_out_d;
        end
    end

    rgb565_block_avg #(
        .RECIP_P (block_recip(BLOCK))
    ) u_avg (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .valid_in  (s1_valid_q),
        .sum_in    (s1_sum_q),
        .valid_out (data_valid_out),
        .pixel_out (pixel_out)
    );

    assign hcount_out = hcount_out_q;
    assign vcount_out = vcount_out_q;

endmodule

// File: tb/tb_pixelate.sv
// Scoreboard bench for pixelate: 320-wide frames with 45 lines so the
// bottom tile row is partial and a frame stays short.
module tb_pixelate;

    localparam int H = 320;
    localparam int V = 45;
    localparam int B = 10;

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic        data_valid_in = 1'b0;
    logic [9:0]  hcount_in = '0;
    logic [10:0] vcount_in = '0;
    logic [15:0] pixel_in = '0;
    logic        data_valid_out;
    logic [4:0]  hcount_out;
    logic [4:0]  vcount_out;
    logic [15:0] pixel_out;

    pixelate #(.H_ACTIVE(H), .V_ACTIVE(V), .BLOCK(B)) dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .data_valid_in  (data_valid_in),
        .hcount_in      (hcount_in),
        .vcount_in      (vcount_in),
        .pixel_in       (pixel_in),
        .data_valid_out (data_valid_out),
        .hcount_out     (hcount_out),
        .vcount_out     (vcount_out),
        .pixel_out      (pixel_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int h;
        int v;
        int pix;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_pix = 0;
    bit   tb_synced = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int pix_of(input int p, input int x, input int y);
        case (p)
            0: return 'hF800;
            1: return 'h001F;
            2: return (x < B && y < B) ? 'h0841 : 0;
            default: return (((x * 7 + y * 3) & 31) << 11) | (((x * x + y * 5) & 63) << 5) | ((x ^ (y * 3)) & 31);
        endcase
    endfunction

    function automatic int exp_avg(input int p, input int tx, input int ty);
        int sr = 0, sg = 0, sb = 0, px;
        for (int yy = 0; yy < B; yy++) begin
            for (int xx = 0; xx < B; xx++) begin
                px = pix_of(p, tx * B + xx, ty * B + yy);
                sr += (px >> 11) & 31;
                sg += (px >> 5) & 63;
                sb += px & 31;
            end
        end
        sr = (sr * 656) >> 16;
        sg = (sg * 656) >> 16;
        sb = (sb * 656) >> 16;
        if (sr > 31) sr = 31;
        if (sg > 63) sg = 63;
        if (sb > 31) sb = 31;
        return (sr << 11) | (sg << 5) | sb;
    endfunction

    // Output monitor: every pulse must match the head of the scoreboard
    always begin
        exp_t e;
        @(posedge clk_in);
        cyc = cyc + 1;
        #1;
        if (rst_n_in && data_valid_out) begin
            if (q.size() == 0) begin
                check_eq("spurious_pulse", 32'(1), 32'(0));
            end else begin
                e = q.pop_front();
                check_eq("tile_h", 32'(hcount_out), 32'(e.h));
                check_eq("tile_v", 32'(vcount_out), 32'(e.v));
                check_eq("tile_pix", 32'(pixel_out), 32'(e.pix));
                check_eq("latency_cyc", 32'(cyc), 32'(e.cyc));
                last_pix = e.pix;
            end
        end
    end

    task automatic idle();
        @(negedge clk_in);
        data_valid_in = 1'b0;
    endtask

    task automatic beat(input int p, input logic [9:0] h, input logic [10:0] v, input logic [15:0] pix);
        exp_t e;
        int   hi, vi;
        @(negedge clk_in);
        data_valid_in = 1'b1;
        hcount_in = h;
        vcount_in = v;
        pixel_in = pix;
        hi = int'(h);
        vi = int'(v);
        if (hi < H && vi < V) begin
            if (hi == 0 && vi == 0) tb_synced = 1'b1;
            if (tb_synced && (hi % B) == B - 1 && (vi % B) == B - 1 && (vi / B) < (V / B)) begin
                e.h = hi / B;
                e.v = vi / B;
                e.pix = exp_avg(p, hi / B, vi / B);
                e.cyc = cyc + 2;
                q.push_back(e);
            end
        end
    endtask

    task automatic frame(input int p, input int y0, input int y1, input bit gaps, input bit junk);
        for (int y = y0; y < y1; y++) begin
            for (int x = 0; x < H; x++) begin
                if (gaps) begin
                    while ($urandom_range(0, 3) == 0) idle();
                end
                if (junk && x == 100) begin
                    beat(p, 10'(H + y % 10), 11'(y), 16'hFFFF);
                    beat(p, 10'(x), 11'(V), 16'hFFFF);
                    beat(p, 10'd0, 11'd240, 16'hFFFF);
                end
                beat(p, 10'(x), 11'(y), 16'(pix_of(p, x, y)));
            end
        end
    endtask

    task automatic drain(input string tag);
        repeat (6) idle();
        check_eq({tag, "_left"}, 32'(q.size()), 32'(0));
        check_eq({tag, "_hold_pix"}, 32'(pixel_out), 32'(last_pix));
        check_eq({tag, "_idle_valid"}, 32'(data_valid_out), 32'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: pixelate bench did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk_in);
        check_eq("rst_valid", 32'(data_valid_out), 32'(0));
        check_eq("rst_pix", 32'(pixel_out), 32'(0));
        check_eq("rst_h", 32'(hcount_out), 32'(0));
        check_eq("rst_v", 32'(vcount_out), 32'(0));
        rst_n_in = 1'b1;

        // Solid red frame including a partial bottom tile row
        frame(0, 0, V, 1'b0, 1'b0);
        drain("solid_red");

        // Same frame with out-of-range beats mixed in
        frame(0, 0, 40, 1'b0, 1'b1);
        drain("junk");

        // Blue frame straight after red: no carry-over
        frame(1, 0, 40, 1'b0, 1'b0);
        drain("blue");

        // Only tile (0,0) lit
        frame(2, 0, 10, 1'b0, 1'b0);
        drain("tile00");

        // Varied pattern with random valid gaps
        frame(3, 0, 20, 1'b1, 1'b0);
        drain("gaps");

        // Async reset mid-line, then stale lines, then a fresh frame
        frame(3, 0, 25, 1'b0, 1'b0);
        for (int x = 0; x < 137; x++) beat(3, 10'(x), 11'd25, 16'(pix_of(3, x, 25)));
        @(negedge clk_in);
        data_valid_in = 1'b0;
        #2 rst_n_in = 1'b0;
        q.delete();
        tb_synced = 1'b0;
        last_pix = 0;
        #1;
        check_eq("arst_valid", 32'(data_valid_out), 32'(0));
        check_eq("arst_pix", 32'(pixel_out), 32'(0));
        check_eq("arst_h", 32'(hcount_out), 32'(0));
        check_eq("arst_v", 32'(vcount_out), 32'(0));
        repeat (2) idle();
        rst_n_in = 1'b1;
        frame(3, 26, 40, 1'b0, 1'b0);
        drain("unsynced");
        frame(3, 0, 20, 1'b0, 1'b0);
        drain("after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
